// File: rtl/decode_sb.sv
// Decode stage with per-register pending-write scoreboard and operand forwarding.
// Define DECODE_SB_STAT_EN to add the saturating stall_cnt output.
module decode_sb #(
  parameter int XLEN  = 32,
  parameter int NFWD  = 3,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [5*NFWD-1:0]    fwd_wd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 ret_we,
  input  logic [4:0]           ret_wd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_alusel,
  output logic [XLEN-1:0]      out_opr1,
  output logic [XLEN-1:0]      out_opr2,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc,
  output logic [4:0]           out_wd,
  output logic                 out_wreg,
  output logic [31:0]          out_inst
`ifdef DECODE_SB_STAT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  // Classes in [4:3]: ALU 00, store/upper 01, branch/jump 10, load 11
  localparam logic [4:0] SEL_LUI   = 5'b01_110;
  localparam logic [4:0] SEL_AUIPC = 5'b01_111;
  localparam logic [4:0] SEL_JAL   = 5'b10_010;
  localparam logic [4:0] SEL_JALR  = 5'b10_011;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt [32];

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic              use1, use2, wreg;
  logic [4:0]        alusel, wd;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm, opr1, opr2;
  logic [XLEN:0]     res1, res2;
  logic              sat, hazard;
  logic              inc, dec;

  // Returns {hazard, value}; lowest-index matching forward port wins
  function automatic logic [XLEN:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf);
    logic         hit;
    logic [XLEN:0] r;
    hit = 1'b0;
    r   = {1'b0, rf};
    if (a == 5'd0) begin
      r = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fwd_we[i] && fwd_wd[5*i +: 5] == a) begin
          hit = 1'b1;
          r   = {!fwd_rdy[i], fwd_data[XLEN*i +: XLEN]};
        end
      end
      if (!hit && cnt[a] != '0) r[XLEN] = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    opcode = in_inst[6:0];
    funct3 = in_inst[14:12];
    rd     = in_inst[11:7];
    rs1_addr = in_inst[19:15];
    rs2_addr = in_inst[24:20];
    use1   = 1'b0;
    use2   = 1'b0;
    wreg   = 1'b0;
    alusel = 5'd0;
    imm32  = '0;
    case (opcode)
      7'b0010011: begin alusel = {2'b00, funct3}; use1 = 1'b1; wreg = 1'b1;
                        imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0110011: begin alusel = {2'b00, funct3}; use1 = 1'b1; use2 = 1'b1; wreg = 1'b1; end
      7'b0110111: begin alusel = SEL_LUI; wreg = 1'b1; imm32 = {in_inst[31:12], 12'b0}; end
      7'b0010111: begin alusel = SEL_AUIPC; wreg = 1'b1; imm32 = {in_inst[31:12], 12'b0}; end
      7'b1101111: begin alusel = SEL_JAL; wreg = 1'b1;
                        imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}; end
      7'b1100111: begin alusel = SEL_JALR; use1 = 1'b1; wreg = 1'b1;
                        imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b1100011: begin alusel = {2'b10, funct3}; use1 = 1'b1; use2 = 1'b1;
                        imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}; end
      7'b0000011: begin alusel = {2'b11, funct3}; use1 = 1'b1; wreg = 1'b1;
                        imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0100011: begin
        if (funct3 <= 3'b010) begin
          alusel = {2'b01, funct3}; use1 = 1'b1; use2 = 1'b1;
          imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end
      end
      default: ;
    endcase
    imm  = XLEN'(imm32);
    wd   = wreg ? rd : 5'd0;
    res1 = use1 ? resolve(rs1_addr, rs1_data) : {1'b0, imm};
    res2 = use2 ? resolve(rs2_addr, rs2_data) : {1'b0, imm};
    opr1 = res1[XLEN-1:0];
    opr2 = res2[XLEN-1:0];
    // A held writer to rd will bump its count on hand-off, so one below max is full too
    sat  = wreg && rd != 5'd0 &&
           (cnt[rd] == CMAX ||
            (cnt[rd] == CNT_W'(CMAX - 1'b1) && out_valid && out_wreg && out_wd == rd));
    hazard   = in_valid && (res1[XLEN] || res2[XLEN] || sat);
    in_ready = !hazard && (!out_valid || out_ready) && !flush && !rst;
    inc = out_valid && out_ready && out_wreg && out_wd != 5'd0 && !flush;
    dec = ret_we && ret_wd != 5'd0;
  end

  // Issue register: holds payload stable until EX accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_alusel <= '0;
      out_opr1   <= '0;
      out_opr2   <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      out_wd     <= '0;
      out_wreg   <= 1'b0;
      out_inst   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid  <= 1'b1;
      out_alusel <= alusel;
      out_opr1   <= opr1;
      out_opr2   <= opr2;
      out_imm    <= imm;
      out_pc     <= in_pc;
      out_wd     <= wd;
      out_wreg   <= wreg;
      out_inst   <= in_inst;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pending-write counters; x0 is never touched after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc && out_wd == 5'(i) && !(dec && ret_wd == 5'(i)))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec && ret_wd == 5'(i) && !(inc && out_wd == 5'(i)) && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef DECODE_SB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if (hazard && stall_cnt != '1)   stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_decode_sb.sv
// Directed bench for decode_sb: decode vector table plus hand-written hazard,
// stall, flush, saturation and reset sequences.
module tb_decode_sb;

  localparam int XLEN = 32;
  localparam int NFWD = 3;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_inst;
  logic [4:0]           rs1_addr, rs2_addr;
  logic [XLEN-1:0]      rs1_data, rs2_data;
  logic [NFWD-1:0]      fwd_we, fwd_rdy;
  logic [5*NFWD-1:0]    fwd_wd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 ret_we;
  logic [4:0]           ret_wd;
  logic                 out_valid, out_ready, out_wreg;
  logic [4:0]           out_alusel, out_wd;
  logic [XLEN-1:0]      out_opr1, out_opr2, out_imm, out_pc;
  logic [31:0]          out_inst;
`ifdef DECODE_SB_STAT_EN
  logic [31:0]          stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  decode_sb #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_we(fwd_we), .fwd_wd(fwd_wd), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
    .ret_we(ret_we), .ret_wd(ret_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_alusel(out_alusel),
    .out_opr1(out_opr1), .out_opr2(out_opr2), .out_imm(out_imm), .out_pc(out_pc),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_inst(out_inst)
`ifdef DECODE_SB_STAT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] alusel, opr1, opr2, imm, wd, wreg;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic vld);
    in_inst  = inst;
    in_valid = vld;
  endtask

  task automatic clearFwd();
    fwd_we = '0; fwd_wd = '0; fwd_data = '0; fwd_rdy = '0;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{"addi",   32'h00500093, 32'h00, 32'h00000000, 32'h00000005, 32'h00000005, 1, 1};
    vecs[1]  = '{"add",    32'h002081B3, 32'h00, 32'h00000100, 32'h00000200, 32'h00000000, 3, 1};
    vecs[2]  = '{"lui",    32'h123452B7, 32'h0E, 32'h12345000, 32'h12345000, 32'h12345000, 5, 1};
    vecs[3]  = '{"beq",    32'hFE208CE3, 32'h10, 32'h00000100, 32'h00000200, 32'hFFFFFFF8, 0, 0};
    vecs[4]  = '{"lw",     32'hFFC0A303, 32'h1A, 32'h00000100, 32'hFFFFFFFC, 32'hFFFFFFFC, 6, 1};
    vecs[5]  = '{"sw",     32'h0020A423, 32'h0A, 32'h00000100, 32'h00000200, 32'h00000008, 0, 0};
    vecs[6]  = '{"sbad",   32'h0020B423, 32'h00, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0};
    vecs[7]  = '{"jal",    32'h010000EF, 32'h12, 32'h00000010, 32'h00000010, 32'h00000010, 1, 1};
    vecs[8]  = '{"jalr",   32'h00008067, 32'h13, 32'h00000100, 32'h00000000, 32'h00000000, 0, 1};
    vecs[9]  = '{"auipc",  32'hFFFFF397, 32'h0F, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 7, 1};
    vecs[10] = '{"badop",  32'h0000007F, 32'h00, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0};
    vecs[11] = '{"xori",   32'hFFF14413, 32'h04, 32'h00000100, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    ret_we = 1'b0; ret_wd = '0;
    rs1_data = 32'h100; rs2_data = 32'h200; in_pc = 32'h1000;
    clearFwd();
    applyStimulus(32'h00500093, 1'b1);

    // Reset state and in_ready low while rst is asserted
    nextCycle(); #1;
    checkOutput("rst.in_ready", {31'd0, in_ready}, 0);
    checkOutput("rst.out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst.out_opr1", out_opr1, 0);
    checkOutput("rst.cnt1", 32'(dut.cnt[1]), 0);

    // Decode table, one fresh reset per vector
    for (int i = 0; i < 12; i++) begin
      rst = 1'b1;
      applyStimulus(32'h0, 1'b0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(vecs[i].inst, 1'b1);
      #1;
      checkOutput({vecs[i].name, ".in_ready"}, {31'd0, in_ready}, 1);
      nextCycle();
      applyStimulus(32'h0, 1'b0);
      #1;
      checkOutput({vecs[i].name, ".valid"}, {31'd0, out_valid}, 1);
      checkOutput({vecs[i].name, ".alusel"}, {27'd0, out_alusel}, vecs[i].alusel);
      checkOutput({vecs[i].name, ".opr1"}, out_opr1, vecs[i].opr1);
      checkOutput({vecs[i].name, ".opr2"}, out_opr2, vecs[i].opr2);
      checkOutput({vecs[i].name, ".imm"}, out_imm, vecs[i].imm);
      checkOutput({vecs[i].name, ".wd"}, {27'd0, out_wd}, vecs[i].wd);
      checkOutput({vecs[i].name, ".wreg"}, {31'd0, out_wreg}, vecs[i].wreg);
      checkOutput({vecs[i].name, ".pc"}, out_pc, 32'h1000);
      checkOutput({vecs[i].name, ".inst"}, out_inst, vecs[i].inst);
    end

    rst = 1'b1;
    nextCycle();
    rst = 1'b0;

    // addi x1,x0,5 issues and bumps counter[1] on hand-off
    applyStimulus(32'h00500093, 1'b1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    #1;
    checkOutput("addi.valid", {31'd0, out_valid}, 1);
    checkOutput("addi.opr1", out_opr1, 0);
    checkOutput("addi.opr2", out_opr2, 5);
    checkOutput("addi.wd", {27'd0, out_wd}, 1);
    nextCycle(); #1;
    checkOutput("addi.cnt1", 32'(dut.cnt[1]), 1);
    checkOutput("addi.drained", {31'd0, out_valid}, 0);

    // add x3,x1,x2: port 0 beats port 2 and overrides the pending scoreboard entry
    fwd_we = 3'b101; fwd_wd = {5'd1, 5'd0, 5'd1};
    fwd_data = {32'h22, 32'h0, 32'h11}; fwd_rdy = 3'b101;
    applyStimulus(32'h002081B3, 1'b1);
    #1;
    checkOutput("fwdpri.in_ready", {31'd0, in_ready}, 1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    clearFwd();
    #1;
    checkOutput("fwdpri.opr1", out_opr1, 32'h11);
    checkOutput("fwdpri.opr2", out_opr2, 32'h200);
    nextCycle();

    // addi x9,x5,1 waits on a not-ready forward value
    fwd_we = 3'b010; fwd_wd = {5'd0, 5'd5, 5'd0};
    fwd_data = {32'h0, 32'h55, 32'h0}; fwd_rdy = 3'b000;
    applyStimulus(32'h00128493, 1'b1);
    #1;
    checkOutput("fwdwait.ready0", {31'd0, in_ready}, 0);
    nextCycle(); #1;
    checkOutput("fwdwait.ready1", {31'd0, in_ready}, 0);
    checkOutput("fwdwait.novalid", {31'd0, out_valid}, 0);
    fwd_rdy = 3'b010;
    #1;
    checkOutput("fwdwait.ready2", {31'd0, in_ready}, 1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    clearFwd();
    #1;
    checkOutput("fwdwait.valid", {31'd0, out_valid}, 1);
    checkOutput("fwdwait.opr1", out_opr1, 32'h55);
    checkOutput("fwdwait.opr2", out_opr2, 1);
    nextCycle();

    // Scoreboard stall on x4 released by retirement
    applyStimulus(32'h00100213, 1'b1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    nextCycle(); #1;
    checkOutput("sb.cnt4", 32'(dut.cnt[4]), 1);
    applyStimulus(32'h00020513, 1'b1);
    #1;
    checkOutput("sb.stall0", {31'd0, in_ready}, 0);
    nextCycle(); #1;
    checkOutput("sb.stall1", {31'd0, in_ready}, 0);
    ret_we = 1'b1; ret_wd = 5'd4;
    nextCycle();
    ret_we = 1'b0;
    #1;
    checkOutput("sb.cnt4ret", 32'(dut.cnt[4]), 0);
    checkOutput("sb.ready", {31'd0, in_ready}, 1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    #1;
    checkOutput("sb.valid", {31'd0, out_valid}, 1);
    checkOutput("sb.opr1", out_opr1, 32'h100);
    checkOutput("sb.wd", {27'd0, out_wd}, 10);
    nextCycle();

    // Backpressure holds payload; flush drops it without counting
    out_ready = 1'b0;
    applyStimulus(32'h00700593, 1'b1);
    nextCycle();
    applyStimulus(32'h00800613, 1'b1);
    #1;
    checkOutput("bp.valid0", {31'd0, out_valid}, 1);
    checkOutput("bp.opr2_0", out_opr2, 7);
    checkOutput("bp.busy", {31'd0, in_ready}, 0);
    nextCycle(); #1;
    checkOutput("bp.valid1", {31'd0, out_valid}, 1);
    checkOutput("bp.opr2_1", out_opr2, 7);
    checkOutput("bp.wd1", {27'd0, out_wd}, 11);
    flush = 1'b1;
    #1;
    checkOutput("bp.flushready", {31'd0, in_ready}, 0);
    nextCycle();
    flush = 1'b0;
    applyStimulus(32'h0, 1'b0);
    #1;
    checkOutput("bp.flushed", {31'd0, out_valid}, 0);
    checkOutput("bp.cnt11", 32'(dut.cnt[11]), 0);
    checkOutput("bp.cnt12", 32'(dut.cnt[12]), 0);
    out_ready = 1'b1;

    // Saturation guard on x12 at count 3
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h00800613, 1'b1);
      nextCycle();
      applyStimulus(32'h0, 1'b0);
      nextCycle();
    end
    #1;
    checkOutput("sat.cnt12", 32'(dut.cnt[12]), 3);
    applyStimulus(32'h00800613, 1'b1);
    #1;
    checkOutput("sat.blocked", {31'd0, in_ready}, 0);
    ret_we = 1'b1; ret_wd = 5'd12;
    nextCycle();
    ret_we = 1'b0;
    #1;
    checkOutput("sat.cnt12ret", 32'(dut.cnt[12]), 2);
    checkOutput("sat.released", {31'd0, in_ready}, 1);
    applyStimulus(32'h0, 1'b0);

    // Simultaneous issue and retire of x12 leaves its count unchanged
    applyStimulus(32'h00800613, 1'b1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    ret_we = 1'b1; ret_wd = 5'd12;
    nextCycle();
    ret_we = 1'b0;
    #1;
    checkOutput("incdec.cnt12", 32'(dut.cnt[12]), 2);

    // x0 writer never counted; retire at zero ignored
    applyStimulus(32'h00000013, 1'b1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    #1;
    checkOutput("x0.wreg", {31'd0, out_wreg}, 1);
    nextCycle(); #1;
    checkOutput("x0.cnt0", 32'(dut.cnt[0]), 0);
    ret_we = 1'b1; ret_wd = 5'd13;
    nextCycle();
    ret_we = 1'b0;
    #1;
    checkOutput("deczero.cnt13", 32'(dut.cnt[13]), 0);

    // Reset while an instruction is held
    out_ready = 1'b0;
    applyStimulus(32'h00700593, 1'b1);
    nextCycle();
    applyStimulus(32'h0, 1'b0);
    #1;
    checkOutput("rstmid.held", {31'd0, out_valid}, 1);
    rst = 1'b1;
    nextCycle(); #1;
    checkOutput("rstmid.valid", {31'd0, out_valid}, 0);
    checkOutput("rstmid.opr2", out_opr2, 0);
    checkOutput("rstmid.inst", out_inst, 0);
    checkOutput("rstmid.cnt12", 32'(dut.cnt[12]), 0);
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef DECODE_SB_STAT_EN
    fwd_we = 3'b001; fwd_wd = {5'd0, 5'd0, 5'd5}; fwd_rdy = 3'b000;
    applyStimulus(32'h00128493, 1'b1);
    repeat (4) nextCycle();
    applyStimulus(32'h0, 1'b0);
    clearFwd();
    #1;
    checkOutput("stat.cnt4", stall_cnt, 4);
    rst = 1'b1;
    nextCycle(); #1;
    checkOutput("stat.rst", stall_cnt, 0);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
